// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port block RAM among NCH requesters.
// Round-robin grant with a valid/ready request handshake. Read responses come
// back in acceptance order, RAM_LAT+1 cycles after the accept edge.
// Optional build macro MEM_ARB_FIXED_PRIO_EN switches to fixed priority.
// In that mode the lowest channel index always wins and there is no pointer.
module mem_port_arbiter #(
  parameter int NCH     = 2,
  parameter int SIZE    = 10,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,        // active-low, asynchronous
  input  logic [NCH-1:0]          req_valid,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH-1:0]          req_we,
  input  logic [NCH*SIZE-1:0]     req_addr,
  input  logic [NCH*DATA_W-1:0]   req_wdata,
  output logic [NCH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    ram_we,
  output logic [SIZE-1:0]         ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata
);

  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            w_gnt_any;  // some channel is requesting
  logic [ID_W-1:0] w_gnt_id;   // index of the winning channel
  logic            w_gnt;      // grant qualified by reset
  logic            w_rd_xfer;  // a read is accepted this cycle

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is the last one kept.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;
  int              w_best;

  // Round robin: pick the requester with the smallest upward distance from the pointer.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_best    = NCH;
    for (int i = 0; i < NCH; i++) begin
      if (req_valid[i] && (((i - int'(r_ptr) + NCH) % NCH) < w_best)) begin
        w_best    = (i - int'(r_ptr) + NCH) % NCH;
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(i);
      end
    end
  end

  // Pointer moves to just past the channel that transferred, wrapping at NCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_gnt) begin
      r_ptr <= (w_gnt_id == ID_W'(NCH - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end
`endif

  // Nothing is granted while reset is held, even though requests may be high.
  assign w_gnt     = w_gnt_any & rst;
  assign w_rd_xfer = w_gnt & ~ram_we;

  // One-hot ready, and the RAM pins are steered from the granted channel.
  always_comb begin
    req_ready = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt && (w_gnt_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        ram_we       = req_we[i];
        ram_addr     = req_addr[i*SIZE +: SIZE];
        ram_wdata    = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  logic            r_pipe_vld [RAM_LAT];
  logic [ID_W-1:0] r_pipe_id  [RAM_LAT];

  // Shift pipe that follows each accepted read through the RAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RAM_LAT; k++) begin
        r_pipe_vld[k] <= 1'b0;
        r_pipe_id[k]  <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_xfer;
      r_pipe_id[0]  <= w_gnt_id;
      for (int k = 1; k < RAM_LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_id[k]  <= r_pipe_id[k-1];
      end
    end
  end

  // Register the RAM output and strobe the owning channel when a read leaves the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (r_pipe_vld[RAM_LAT-1]) begin
        rsp_rdata <= ram_rdata;
        for (int i = 0; i < NCH; i++) begin
          rsp_valid[i] <= (r_pipe_id[RAM_LAT-1] == ID_W'(i));
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A behavioural block RAM with
// RAM_LAT-cycle read latency is attached. The stimulus process checks the
// combinational grant and RAM pins against a reference model and queues the
// expected read responses. A negedge monitor pops the queue and checks each
// response. Honours MEM_ARB_FIXED_PRIO_EN in the same way as the design.
module tb_mem_port_arbiter;

  localparam int NCH     = 3;
  localparam int SIZE    = 10;
  localparam int DATA_W  = 32;
  localparam int RAM_LAT = 3;

  logic                  clk;
  logic                  rst;
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0]        req_we;
  logic [NCH*SIZE-1:0]   req_addr;
  logic [NCH*DATA_W-1:0] req_wdata;
  logic [NCH-1:0]        rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  ram_we;
  logic [SIZE-1:0]       ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  mem_port_arbiter #(.NCH(NCH), .SIZE(SIZE), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM environment model: write on the edge, read data after RAM_LAT edges.
  logic [DATA_W-1:0] ram_mem  [1<<SIZE];
  logic [DATA_W-1:0] ram_pipe [RAM_LAT];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_pipe[0] <= ram_mem[ram_addr];
    for (int k = 1; k < RAM_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign ram_rdata = ram_pipe[RAM_LAT-1];

  // Reference state.
  logic [DATA_W-1:0] ref_mem [1<<SIZE];
  int                ref_ptr = 0;
  typedef struct {
    int                due;
    int                ch;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t              q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] last_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Staged stimulus, applied at the start of the next step.
  logic [NCH-1:0]    stg_valid;
  logic [NCH-1:0]    stg_we;
  logic [SIZE-1:0]   stg_addr  [NCH];
  logic [DATA_W-1:0] stg_wdata [NCH];

  task automatic stage_idle();
    stg_valid = '0;
    stg_we    = '0;
    for (int i = 0; i < NCH; i++) begin
      stg_addr[i]  = '0;
      stg_wdata[i] = '0;
    end
  endtask

  task automatic stage_req(input int ch, input logic we, input int addr, input logic [DATA_W-1:0] d);
    stg_valid[ch] = 1'b1;
    stg_we[ch]    = we;
    stg_addr[ch]  = SIZE'(addr);
    stg_wdata[ch] = d;
  endtask

  // One clock cycle: apply stimulus, check grant/RAM pins, advance the model.
  task automatic step(input logic rst_v);
    int g;
    @(posedge clk);
    #1;
    rst       = rst_v;
    req_valid = stg_valid;
    req_we    = stg_we;
    for (int i = 0; i < NCH; i++) begin
      req_addr[i*SIZE +: SIZE]       = stg_addr[i];
      req_wdata[i*DATA_W +: DATA_W]  = stg_wdata[i];
    end
    #1;
    g = -1;
    if (!rst_v) begin
      q.delete();
      ref_ptr   = 0;
      last_data = '0;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    end else begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = NCH - 1; i >= 0; i--) if (stg_valid[i]) g = i;
`else
      for (int d = NCH - 1; d >= 0; d--) if (stg_valid[(ref_ptr + d) % NCH]) g = (ref_ptr + d) % NCH;
`endif
    end
    check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    check("ram_we", 64'(ram_we), (g >= 0) ? 64'(stg_we[g]) : 64'd0);
    check("ram_addr", 64'(ram_addr), (g >= 0) ? 64'(stg_addr[g]) : 64'd0);
    if (g >= 0) begin
      $display("acc cyc=%0d ch=%0d we=%0d addr=%0h wdata=%0h", cyc, g, stg_we[g], stg_addr[g], stg_wdata[g]);
      if (stg_we[g]) check("ram_wdata", 64'(ram_wdata), 64'(stg_wdata[g]));
      ref_ptr = (g + 1) % NCH;
      if (stg_we[g]) ref_mem[stg_addr[g]] = stg_wdata[g];
      else q.push_back('{due: cyc + RAM_LAT + 1, ch: g, data: ref_mem[stg_addr[g]]});
    end
  endtask

  // Response monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (q.size() == 0) begin
        check("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
        check("rsp_chan", 64'(rsp_valid), 64'd1 << mon_e.ch);
        check("rsp_data", 64'(rsp_rdata), 64'(mon_e.data));
        $display("rsp cyc=%0d ch=%0d data=%0h", cyc, mon_e.ch, rsp_rdata);
        last_data = mon_e.data;
      end
    end else begin
      check("rsp_hold", 64'(rsp_rdata), 64'(last_data));
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("rsp_missing", 64'(rsp_valid), 64'd1 << q[0].ch);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int a = 0; a < (1 << SIZE); a++) begin
      ram_mem[a] = '0;
      ref_mem[a] = '0;
    end
    for (int k = 0; k < RAM_LAT; k++) ram_pipe[k] = '0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    stage_idle();
    #1 rst = 1'b0;

    // Reset held with every channel requesting; first grant after release goes to ch0.
    stg_valid = '1;
    for (int c = 0; c < 10; c++) step(1'b0);
    step(1'b1);
    stage_idle();
    for (int c = 0; c < 6; c++) step(1'b1);

    // Single write then read-back of the same address.
    stage_req(0, 1'b1, 50, 32'hDEADBEEF); step(1'b1);
    stage_idle(); stage_req(0, 1'b0, 50, '0); step(1'b1);
    stage_idle();
    for (int c = 0; c < 6; c++) step(1'b1);

    // Preload 1..4, then four back-to-back reads.
    for (int a = 1; a <= 4; a++) begin
      stage_idle(); stage_req(0, 1'b1, a, DATA_W'(11 * a)); step(1'b1);
    end
    for (int a = 1; a <= 4; a++) begin
      stage_idle(); stage_req((a - 1) % NCH, 1'b0, a, '0); step(1'b1);
    end
    stage_idle();
    for (int c = 0; c < 6; c++) step(1'b1);

    // Contention: every channel reads its own preloaded address continuously.
    for (int i = 0; i < NCH; i++) begin
      stage_idle(); stage_req(i, 1'b1, 100 + i, DATA_W'(32'hA0 + i)); step(1'b1);
    end
    stage_idle();
    for (int i = 0; i < NCH; i++) stage_req(i, 1'b0, 100 + i, '0);
    for (int c = 0; c < 12; c++) step(1'b1);

    // ch0 and ch1 both requesting for 20 cycles.
    stage_idle(); stage_req(0, 1'b0, 100, '0); stage_req(1, 1'b0, 101, '0);
    for (int c = 0; c < 20; c++) step(1'b1);
    stage_idle();
    for (int c = 0; c < 6; c++) step(1'b1);

    // Mid-flight reset: the read in flight must never answer; pointer returns to 0.
    stage_req(1, 1'b0, 101, '0); step(1'b1);
    stage_idle(); step(1'b0);
    for (int c = 0; c < 7; c++) step(1'b1);
    stg_valid = '1; step(1'b1);
    stage_idle(); step(1'b1);

    // Randomized traffic on a small address window to provoke write/read hazards.
    for (int c = 0; c < 400; c++) begin
      stage_idle();
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) != 0)
          stage_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DATA_W'($urandom));
      end
      step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
    end

    stage_idle();
    for (int c = 0; c < RAM_LAT + 4; c++) step(1'b1);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one single-port blram among several SimpleCPU-side requesters (instruction fetch, data, DMA).
- Sits between the requesters and the blram addr/data/we pins.
- Round-robin grant with valid/ready request handshake and in-order read responses tracked through the RAM read latency.

Parameters:
- NCH, 2, number of requester channels (1..8).
- SIZE, 10, RAM address width in bits.
- DATA_W, 32, data width in bits.
- RAM_LAT, 1, RAM read latency in cycles from address presented to o_ram_data_out valid (1..4).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous active-low reset; rst=0 resets all state immediately.
- req_valid  in  NCH  per-channel request valid.
- req_ready  out  NCH  per-channel request accepted this cycle.
- req_we  in  NCH  per-channel write flag (1=write, 0=read).
- req_addr  in  NCH*SIZE  flattened addresses; channel i occupies bits [i*SIZE +: SIZE].
- req_wdata  in  NCH*DATA_W  flattened write data.
- rsp_valid  out  NCH  per-channel read-data-valid strobe, one cycle wide.
- rsp_rdata  out  DATA_W  read data, shared by all channels; qualified by rsp_valid.
- ram_we  out  1  to blram i_we.
- ram_addr  out  SIZE  to blram i_addr.
- ram_wdata  out  DATA_W  to blram i_ram_data_in.
- ram_rdata  in  DATA_W  from blram o_ram_data_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Round-robin pointer = 0.
  - Response pipeline cleared.
- Arbitration (combinational, each cycle):
  - Among channels with req_valid=1, grant the first at or after the pointer, searching upward with wrap from NCH-1 to 0.
  - Exactly one req_ready is high when any req_valid is high; none otherwise.
  - A transfer happens when req_valid & req_ready are both high; at most one per cycle.
- RAM drive:
  - ram_we/ram_addr/ram_wdata are combinational from the granted channel in the same cycle.
  - ram_we=0 and ram_addr holds 0 when there is no grant.
  - blram captures on the next posedge.
- Pointer update: on a transfer from channel g, the pointer becomes (g+1) mod NCH. It is unchanged with no transfer.
- Read tracking:
  - Each read transfer pushes {valid=1, channel id} into a RAM_LAT-deep shift pipe; writes and idle cycles push valid=0.
  - When an entry exits the pipe: rsp_valid[id]=1 for one cycle and rsp_rdata=ram_rdata, registered.
  - Total read latency = RAM_LAT+1 cycles from the accept edge.
  - rsp_rdata holds its last value when rsp_valid=0.
- Throughput:
  - Back-to-back reads from any channels are accepted every cycle.
  - Responses return in acceptance order with no stalls; requesters cannot backpressure responses.
- Write then read to the same address on consecutive cycles returns the new data, since blram writes on the edge before the read is sampled.
- Simultaneous requests from all channels: each channel is served once per NCH cycles, with no starvation.
- A channel dropping req_valid without ready is legal; its request is simply withdrawn.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid fires after rst deasserts.
- NCH=1: the arbiter degenerates to pass-through, req_ready=req_valid.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest channel index wins, and the pointer logic is removed. Channel 0 (instruction fetch) is never delayed by other channels; higher channels may starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold rst=0 for 10 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, ram_we=0 throughout; first grant after release goes to ch0.
- Single write/read, NCH=2, RAM_LAT=1: ch0 writes 0xDEADBEEF to addr 50, then ch0 reads 50 the next cycle -> rsp_valid[0]=1 exactly 2 cycles after the read accept, rsp_rdata=0xDEADBEEF.
- Contention, NCH=3, all channels continuously issuing reads -> grants cycle 0,1,2,0,1,2; each rsp_valid returns to its own channel with data from its own address.
- Pipelined latency, RAM_LAT=3: 4 back-to-back reads of addrs 1-4 preloaded with 11,22,33,44 -> rsp_valid high on 4 consecutive cycles starting 4 cycles after the first accept, data 11,22,33,44 in order.
- Mid-flight reset: accept a read, drop rst for 1 cycle before the response -> no rsp_valid afterwards, pointer=0.
- MEM_ARB_FIXED_PRIO_EN defined, ch0 and ch1 both requesting continuously for 20 cycles -> ch0 granted all 20 cycles, ch1 req_ready never high.
